// File: rtl/timeout_sched.sv
// Shared timeout counter: round-robin grants one requester at a time the WIDTH-bit
// down-counter, counts it to zero and holds the expiry until the consumer takes it.
module timeout_sched #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 16,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_cycles_i,
    input  logic                     abort_i,
    output logic                     busy_o,
    output logic [IDW-1:0]           active_id_o,
    output logic [WIDTH-1:0]         count_o,
    output logic                     expire_valid_o,
    output logic [IDW-1:0]           expire_id_o,
    input  logic                     expire_ready_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } state_t;

    localparam logic [IDW:0]   NREQ    = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;

    logic               win_found;
    logic [IDW-1:0]     win_id;
    logic [IDW:0]       cand;
    logic [WIDTH-1:0]   win_cycles;
    logic [NUM_REQ-1:0] grant;

    // Rotating priority scan: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!win_found && req_valid_i[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[IDW-1:0];
            end
        end
    end

    assign win_cycles = req_cycles_i[int'(win_id)*WIDTH +: WIDTH];

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        grant    = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant[win_id] = 1'b1;
                    // A zero-length request still owns the counter for one cycle.
                    count_d  = (win_cycles == '0) ? WIDTH'(1) : win_cycles;
                    id_d     = win_id;
                    rr_ptr_d = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (abort_i) begin
                    count_d = '0;
                    id_d    = '0;
                    state_d = IDLE;
                end else if (count_q <= WIDTH'(1)) begin
                    count_d = '0;
                    state_d = EXPIRE;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            EXPIRE: begin
                if (expire_ready_i) begin
                    id_d    = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                count_d = '0;
                id_d    = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            count_q  <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // The grant is combinational from req_valid_i, so it is masked while reset is held.
    assign req_ready_o    = rst_i ? '0 : grant;
    assign busy_o         = (state_q != IDLE);
    assign active_id_o    = id_q;
    assign count_o        = count_q;
    assign expire_valid_o = (state_q == EXPIRE);
    assign expire_id_o    = id_q;

endmodule

// File: tb/tb_timeout_sched.sv
// Directed bench for timeout_sched: a per-cycle vector table for the basic flow,
// plus hand sequences for round-robin fairness, expiry back-pressure and async reset.
module tb_timeout_sched;

    localparam int NR = 4;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] rv;
    logic [NR-1:0] rdy;
    logic [W-1:0]  cyc;
    logic          ab;
    logic          busy;
    logic [1:0]    aid;
    logic [W-1:0]  cnt;
    logic          ev;
    logic [1:0]    eid;
    logic          er;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    timeout_sched #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (rv),
        .req_ready_o    (rdy),
        .req_cycles_i   ({NR{cyc}}),
        .abort_i        (ab),
        .busy_o         (busy),
        .active_id_o    (aid),
        .count_o        (cnt),
        .expire_valid_o (ev),
        .expire_id_o    (eid),
        .expire_ready_i (er)
    );

    typedef struct {
        logic [3:0]  rv;
        logic [15:0] cyc;
        logic        ab;
        logic        er;
        logic [3:0]  rdy;
        logic        busy;
        logic [1:0]  aid;
        logic [15:0] cnt;
        logic        ev;
        logic [1:0]  eid;
    } vec_t;

    localparam int NV = 23;
    vec_t tv[NV];

    function automatic vec_t mk(logic [3:0] i_rv, int i_cyc, logic i_ab, logic i_er,
                                logic [3:0] o_rdy, logic o_busy, int o_aid, int o_cnt,
                                logic o_ev, int o_eid);
        vec_t v;
        v.rv = i_rv; v.cyc = 16'(i_cyc); v.ab = i_ab; v.er = i_er;
        v.rdy = o_rdy; v.busy = o_busy; v.aid = 2'(o_aid); v.cnt = 16'(o_cnt);
        v.ev = o_ev; v.eid = 2'(o_eid);
        return v;
    endfunction

    function automatic logic [25:0] outs_now();
        return {rdy, busy, aid, cnt, ev, eid};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change at posedge+2, outputs are sampled at posedge+5.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rv = '0; cyc = '0; ab = 1'b0; er = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   gcount;
        logic saw_ev;
        logic [3:0] exp_oh;

        // rr_ptr starts at 0 after reset; rows are consecutive clock cycles.
        tv[0]  = mk(4'b0001,  5, 0, 0, 4'b0001, 0, 0,  0, 0, 0);
        tv[1]  = mk(4'b0000,  5, 0, 0, 4'b0000, 1, 0,  5, 0, 0);
        tv[2]  = mk(4'b0000,  5, 0, 0, 4'b0000, 1, 0,  4, 0, 0);
        tv[3]  = mk(4'b0000,  5, 0, 0, 4'b0000, 1, 0,  3, 0, 0);
        tv[4]  = mk(4'b0000,  5, 0, 0, 4'b0000, 1, 0,  2, 0, 0);
        tv[5]  = mk(4'b0000,  5, 0, 0, 4'b0000, 1, 0,  1, 0, 0);
        tv[6]  = mk(4'b0000,  5, 0, 1, 4'b0000, 1, 0,  0, 1, 0);
        tv[7]  = mk(4'b0100,  0, 0, 0, 4'b0100, 0, 0,  0, 0, 0);
        tv[8]  = mk(4'b0000,  0, 0, 0, 4'b0000, 1, 2,  1, 0, 2);
        tv[9]  = mk(4'b0000,  0, 0, 1, 4'b0000, 1, 2,  0, 1, 2);
        tv[10] = mk(4'b0011, 10, 0, 0, 4'b0001, 0, 0,  0, 0, 0);
        tv[11] = mk(4'b0000, 10, 0, 0, 4'b0000, 1, 0, 10, 0, 0);
        tv[12] = mk(4'b0000, 10, 0, 0, 4'b0000, 1, 0,  9, 0, 0);
        tv[13] = mk(4'b0000, 10, 0, 0, 4'b0000, 1, 0,  8, 0, 0);
        tv[14] = mk(4'b0000, 10, 1, 0, 4'b0000, 1, 0,  7, 0, 0);
        tv[15] = mk(4'b0011,  1, 0, 0, 4'b0010, 0, 0,  0, 0, 0);
        tv[16] = mk(4'b0000,  1, 1, 0, 4'b0000, 1, 1,  1, 0, 1);
        tv[17] = mk(4'b0001,  2, 1, 0, 4'b0001, 0, 0,  0, 0, 0);
        tv[18] = mk(4'b0000,  2, 0, 0, 4'b0000, 1, 0,  2, 0, 0);
        tv[19] = mk(4'b0000,  2, 0, 0, 4'b0000, 1, 0,  1, 0, 0);
        tv[20] = mk(4'b0000,  2, 1, 0, 4'b0000, 1, 0,  0, 1, 0);
        tv[21] = mk(4'b0000,  2, 0, 1, 4'b0000, 1, 0,  0, 1, 0);
        tv[22] = mk(4'b0000,  2, 0, 0, 4'b0000, 0, 0,  0, 0, 0);

        // Reset state, with every request raised to show the grant is masked.
        rst = 1'b1; rv = 4'b1111; cyc = 16'd3; ab = 1'b0; er = 1'b0;
        #3;
        chk("reset_outputs", 64'(outs_now()), 64'd0);
        tick();
        rst = 1'b0;
        rv  = '0;

        for (int i = 0; i < NV; i++) begin
            v = tv[i];
            rv = v.rv; cyc = v.cyc; ab = v.ab; er = v.er;
            #3;
            chk($sformatf("vec%0d", i), 64'(outs_now()),
                64'({v.rdy, v.busy, v.aid, v.cnt, v.ev, v.eid}));
            tick();
        end

        // All four requesting continuously with 1-cycle timeouts: grants every 3 cycles.
        do_reset();
        rv = 4'b1111; cyc = 16'd1; er = 1'b1;
        gcount = 0;
        for (int c = 0; c < 15; c++) begin
            #3;
            if (rdy != '0) begin
                if (gcount < 5) begin
                    exp_oh = 4'b0001 << (gcount % 4);
                    chk($sformatf("rr_grant%0d", gcount), 64'({c[7:0], rdy}),
                        64'({8'(gcount * 3), exp_oh}));
                end
                gcount++;
            end
            tick();
        end
        chk("rr_grant_total", 64'(gcount), 64'd5);

        // Expiry held under back-pressure; no grant until the cycle after acceptance.
        do_reset();
        rv = 4'b0001; cyc = 16'd2; er = 1'b0;
        tick();
        rv = '0;
        for (int c = 0; c < 10 && !ev; c++) begin
            tick();
        end
        #3;
        chk("bp_expire_seen", 64'(ev), 64'd1);
        tick();
        rv = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #3;
            chk($sformatf("bp_hold%0d", c), 64'({ev, eid, rdy, busy}), 64'({1'b1, 2'd0, 4'b0000, 1'b1}));
            tick();
        end
        er = 1'b1;
        #3;
        chk("bp_accept_cycle", 64'({ev, rdy}), 64'({1'b1, 4'b0000}));
        tick();
        er = 1'b0;
        #3;
        chk("bp_next_grant", 64'({ev, busy, rdy}), 64'({1'b0, 1'b0, 4'b0010}));
        tick();

        // Asynchronous reset in RUN with count 7: outputs clear at once, rr_ptr back to 0.
        do_reset();
        rv = 4'b0100; cyc = 16'd10;
        #3;
        chk("rst_grant2", 64'(rdy), 64'(4'b0100));
        tick();
        rv = '0;
        for (int c = 0; c < 3; c++) tick();
        #3;
        chk("rst_pre_count", 64'({busy, aid, cnt}), 64'({1'b1, 2'd2, 16'd7}));
        rv = 4'b1111;
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_clear", 64'(outs_now()), 64'd0);
        tick();
        rst = 1'b0;
        rv = '0;
        saw_ev = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #3;
            if (ev || busy) saw_ev = 1'b1;
            tick();
        end
        chk("rst_no_expiry", 64'(saw_ev), 64'd0);
        rv = 4'b1111;
        #3;
        chk("rst_rr_ptr0", 64'(rdy), 64'(4'b0001));
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
